// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline constants, the fetch-stage action decode and a PC helper.
// Used by the IF, ID and hazard-logic blocks.
package mips_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FetchHold,
    FetchRedirect,
    FetchWait,
    FetchNormal
  } fetch_act_e;

  // Priority: hazard stall > redirect > memory wait > normal.
  function automatic fetch_act_e fetch_action(input logic hazard_stall,
                                              input logic redirect,
                                              input logic imem_ready);
    if (hazard_stall) return FetchHold;
    if (redirect)     return FetchRedirect;
    if (!imem_ready)  return FetchWait;
    return FetchNormal;
  endfunction

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Generic inter-stage pipeline register: instruction, PC+4 and valid bit.
// Priority hold > bubble > load; otherwise contents are kept.
module if_id_reg
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            hold_i,
  input  logic            bubble_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc4_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc4_o,
  output logic            valid_o
);

  logic [XLEN-1:0] instr_d, instr_q;
  logic [XLEN-1:0] pc4_d, pc4_q;
  logic            valid_d, valid_q;

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (hold_i) begin
      instr_d = instr_q;
    end else if (bubble_i) begin
      instr_d = NOP_INSTR;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (load_i) begin
      instr_d = instr_i;
      pc4_d   = pc4_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS32 instruction-fetch stage: PC register, imem request, IF/ID register, perf counters.
// Define BRANCH_DELAY_SLOT_EN to keep the delay-slot word on a taken redirect.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int unsigned     CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hazard_stall_i,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_target_i,
  output logic [XLEN-1:0]  imem_addr_o,
  input  logic [XLEN-1:0]  imem_instr_i,
  input  logic             imem_ready_i,
  output logic [XLEN-1:0]  if_id_instr_o,
  output logic [XLEN-1:0]  if_id_pc4_o,
  output logic             if_id_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic [XLEN-1:0]  pc_d, pc_q;
  logic [XLEN-1:0]  pc4;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
  logic             ifid_hold, ifid_bubble, ifid_load;
  logic             stall_inc, flush_inc;
  fetch_act_e       act;

  assign pc4 = pc_plus4(pc_q);

  always_comb begin
    act         = fetch_action(hazard_stall_i, redirect_i, imem_ready_i);
    pc_d        = pc_q;
    ifid_hold   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_load   = 1'b0;
    flush_inc   = 1'b0;
    stall_inc   = hazard_stall_i | ~imem_ready_i;
    unique case (act)
      FetchHold: ifid_hold = 1'b1;
      FetchRedirect: begin
        pc_d = {redirect_target_i[XLEN-1:2], 2'b00};
`ifdef BRANCH_DELAY_SLOT_EN
        ifid_load   = imem_ready_i;
        ifid_bubble = ~imem_ready_i;
`else
        ifid_bubble = 1'b1;
        flush_inc   = imem_ready_i;  // only a real fetch counts as squashed
`endif
      end
      FetchWait: ifid_bubble = 1'b1;
      default: begin
        pc_d      = pc4;
        ifid_load = 1'b1;
      end
    endcase
    stall_cnt_d = stall_cnt_q + CNT_W'(stall_inc);
    flush_cnt_d = flush_cnt_q + CNT_W'(flush_inc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_VECTOR;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .hold_i   (ifid_hold),
    .bubble_i (ifid_bubble),
    .load_i   (ifid_load),
    .instr_i  (imem_instr_i),
    .pc4_i    (pc4),
    .instr_o  (if_id_instr_o),
    .pc4_o    (if_id_pc4_o),
    .valid_o  (if_id_valid_o)
  );

  assign imem_addr_o = pc_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected post-edge state is queued with each stimulus
// cycle and compared one edge later. Honours BRANCH_DELAY_SLOT_EN like the design.
module tb_fetch_stage;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit Bds = 1'b1;
`else
  localparam bit Bds = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        hazard_stall_i;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        imem_ready_i;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc4_o;
  logic        if_id_valid_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  // Instruction memory model: word = address ^ 32'hA5A5_0000.
  assign imem_instr_i = imem_addr_o ^ 32'hA5A5_0000;

  fetch_stage #(
    .RESET_VECTOR (32'h0000_0000),
    .CNT_W        (32)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .hazard_stall_i    (hazard_stall_i),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i),
    .imem_addr_o       (imem_addr_o),
    .imem_instr_i      (imem_instr_i),
    .imem_ready_i      (imem_ready_i),
    .if_id_instr_o     (if_id_instr_o),
    .if_id_pc4_o       (if_id_pc4_o),
    .if_id_valid_o     (if_id_valid_o),
    .stall_cnt_o       (stall_cnt_o),
    .flush_cnt_o       (flush_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Drive one cycle, queue its expected result, then compare after the edge.
  task automatic step(input string tag, input logic rst, input logic hs, input logic rd,
                      input logic [31:0] tgt, input logic rdy,
                      input logic [31:0] e_pc, input logic [31:0] e_instr,
                      input logic [31:0] e_pc4, input logic e_valid,
                      input logic [31:0] e_stall, input logic [31:0] e_flush);
    exp_t e;
    reset             = rst;
    hazard_stall_i    = hs;
    redirect_i        = rd;
    redirect_target_i = tgt;
    imem_ready_i      = rdy;
    e = '{tag, e_pc, e_instr, e_pc4, e_valid, e_stall, e_flush};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, ".pc"},    imem_addr_o,           e.pc);
      check({e.tag, ".instr"}, if_id_instr_o,         e.instr);
      check({e.tag, ".pc4"},   if_id_pc4_o,           e.pc4);
      check({e.tag, ".valid"}, {31'd0, if_id_valid_o}, {31'd0, e.valid});
      check({e.tag, ".stall"}, stall_cnt_o,           e.stall);
      check({e.tag, ".flush"}, flush_cnt_o,           e.flush);
    end
  endtask

  initial begin
    reset = 1'b1; hazard_stall_i = 1'b0; redirect_i = 1'b0;
    redirect_target_i = '0; imem_ready_i = 1'b1;
    @(posedge clk);
    #1;

    //    tag          rst hs rd target        rdy pc            instr          pc4    v  stl flush
    step("reset",      1, 0, 0, 32'h0,        1, 32'h0,        32'h0,         32'h0,  0, 0, 0);
    step("run0",       0, 0, 0, 32'h0,        1, 32'h4,        32'hA5A5_0000, 32'h4,  1, 0, 0);
    step("run4",       0, 0, 0, 32'h0,        1, 32'h8,        32'hA5A5_0004, 32'h8,  1, 0, 0);
    step("run8",       0, 0, 0, 32'h0,        1, 32'hC,        32'hA5A5_0008, 32'hC,  1, 0, 0);
    step("runC",       0, 0, 0, 32'h0,        1, 32'h10,       32'hA5A5_000C, 32'h10, 1, 0, 0);
    step("haz1",       0, 1, 0, 32'h0,        1, 32'h10,       32'hA5A5_000C, 32'h10, 1, 1, 0);
    step("haz2",       0, 1, 0, 32'h0,        1, 32'h10,       32'hA5A5_000C, 32'h10, 1, 2, 0);
    step("resume",     0, 0, 0, 32'h0,        1, 32'h14,       32'hA5A5_0010, 32'h14, 1, 2, 0);
    step("run14",      0, 0, 0, 32'h0,        1, 32'h18,       32'hA5A5_0014, 32'h18, 1, 2, 0);
    step("run18",      0, 0, 0, 32'h0,        1, 32'h1C,       32'hA5A5_0018, 32'h1C, 1, 2, 0);
    step("run1C",      0, 0, 0, 32'h0,        1, 32'h20,       32'hA5A5_001C, 32'h20, 1, 2, 0);
    step("redir103",   0, 0, 1, 32'h103,      1, 32'h100,
         Bds ? 32'hA5A5_0020 : 32'h0, Bds ? 32'h24 : 32'h0, Bds, 2, Bds ? 0 : 1);
    step("redir_haz",  0, 1, 1, 32'h200,      1, 32'h100,
         Bds ? 32'hA5A5_0020 : 32'h0, Bds ? 32'h24 : 32'h0, Bds, 3, Bds ? 0 : 1);
    step("redir200",   0, 0, 1, 32'h200,      1, 32'h200,
         Bds ? 32'hA5A5_0100 : 32'h0, Bds ? 32'h104 : 32'h0, Bds, 3, Bds ? 0 : 2);
    step("redir40",    0, 0, 1, 32'h41,       1, 32'h40,
         Bds ? 32'hA5A5_0200 : 32'h0, Bds ? 32'h204 : 32'h0, Bds, 3, Bds ? 0 : 3);
    step("wait1",      0, 0, 0, 32'h0,        0, 32'h40,       32'h0,         32'h0,  0, 4, Bds ? 0 : 3);
    step("wait2",      0, 0, 0, 32'h0,        0, 32'h40,       32'h0,         32'h0,  0, 5, Bds ? 0 : 3);
    step("wait3",      0, 0, 0, 32'h0,        0, 32'h40,       32'h0,         32'h0,  0, 6, Bds ? 0 : 3);
    step("run40",      0, 0, 0, 32'h0,        1, 32'h44,       32'hA5A5_0040, 32'h44, 1, 6, Bds ? 0 : 3);
    step("redir_top",  0, 0, 1, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFC,
         Bds ? 32'hA5A5_0044 : 32'h0, Bds ? 32'h48 : 32'h0, Bds, 6, Bds ? 0 : 4);
    step("wrap",       0, 0, 0, 32'h0,        1, 32'h0,        32'h5A5A_FFFC, 32'h0,  1, 6, Bds ? 0 : 4);
    step("run0b",      0, 0, 0, 32'h0,        1, 32'h4,        32'hA5A5_0000, 32'h4,  1, 6, Bds ? 0 : 4);
    step("wait_pre",   0, 0, 0, 32'h0,        0, 32'h4,        32'h0,         32'h0,  0, 7, Bds ? 0 : 4);
    step("rst_wait",   1, 0, 0, 32'h0,        0, 32'h0,        32'h0,         32'h0,  0, 0, 0);
    step("post_rst",   0, 0, 0, 32'h0,        1, 32'h4,        32'hA5A5_0000, 32'h4,  1, 0, 0);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net: the stimulus is a fixed sequence, so this only fires if simulation stalls.
  initial begin
    #5000;
    $display("FAIL timeout: got %0d checks expected completion", n_checks);
    $fatal(1);
  end

endmodule
